// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide over magnitudes, sign fix-up in a final cycle.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_hilo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             stall
);

    localparam int unsigned W     = WIDTH;
    localparam int unsigned AW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [AW-1:0]    r_acc, w_acc_nxt;
    logic [W-1:0]     r_opnd, w_opnd_nxt;
    logic             r_neg1, w_neg1_nxt;
    logic             r_neg2, w_neg2_nxt;
    logic             r_is_div, w_is_div_nxt;
    logic             r_div0, w_div0_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [W-1:0]     r_hi, w_hi_nxt;
    logic [W-1:0]     r_lo, w_lo_nxt;

    // Operand magnitudes: only signed ops (op[0]==0) take the two's-complement absolute value
    logic         w_neg1, w_neg2;
    logic [W-1:0] w_mag1, w_mag2;
    assign w_neg1 = ~op[0] & in1[W-1];
    assign w_neg2 = ~op[0] & in2[W-1];
    assign w_mag1 = w_neg1 ? -in1 : in1;
    assign w_mag2 = w_neg2 ? -in2 : in2;

    // Multiply step: add multiplicand into upper half when the multiplier LSB is set, shift right
    logic [W:0]    w_sum;
    logic [AW-1:0] w_mul_acc;
    assign w_sum     = {1'b0, r_acc[AW-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_acc = {w_sum, r_acc[W-1:1]};

    // Divide step: shift {rem, quotient} left, trial-subtract divisor from the (W+1)-bit remainder
    logic [W:0]    w_part;
    logic          w_ge;
    logic [W-1:0]  w_diff;
    logic [AW-1:0] w_div_acc;
    assign w_part    = r_acc[AW-1:W-1];
    assign w_ge      = w_part >= {1'b0, r_opnd};
    assign w_diff    = w_part[W-1:0] - r_opnd;
    assign w_div_acc = {(w_ge ? w_diff : w_part[W-1:0]), r_acc[W-2:0], w_ge};

    // Sign correction applied in FIX
    logic [AW-1:0] w_prod;
    logic [W-1:0]  w_quo, w_rem;
    assign w_prod = (r_neg1 ^ r_neg2) ? -r_acc : r_acc;
    assign w_quo  = r_div0 ? '1 : ((r_neg1 ^ r_neg2) ? -r_acc[W-1:0] : r_acc[W-1:0]);
    assign w_rem  = r_neg1 ? -r_acc[AW-1:W] : r_acc[AW-1:W];

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_opnd_nxt   = r_opnd;
        w_neg1_nxt   = r_neg1;
        w_neg2_nxt   = r_neg2;
        w_is_div_nxt = r_is_div;
        w_div0_nxt   = r_div0;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (hi_we) w_hi_nxt = wdata;
                if (lo_we) w_lo_nxt = wdata;
                if (start && !flush) begin
                    w_state_nxt  = S_CALC;
                    w_cnt_nxt    = '0;
                    w_neg1_nxt   = w_neg1;
                    w_neg2_nxt   = w_neg2;
                    w_is_div_nxt = op[1];
                    w_div0_nxt   = op[1] && (in2 == '0);
                    w_acc_nxt    = {{W{1'b0}}, (op[1] ? w_mag1 : w_mag2)};
                    w_opnd_nxt   = op[1] ? w_mag2 : w_mag1;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_acc_nxt = r_is_div ? w_div_acc : w_mul_acc;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(W - 1)) begin
                        w_state_nxt = S_FIX;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
                if (!flush) begin
                    w_done_nxt = 1'b1;
                    if (r_is_div) begin
                        w_hi_nxt = w_rem;
                        w_lo_nxt = w_quo;
                    end else begin
                        w_hi_nxt = w_prod[AW-1:W];
                        w_lo_nxt = w_prod[W-1:0];
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg1   <= 1'b0;
            r_neg2   <= 1'b0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_acc    <= w_acc_nxt;
            r_opnd   <= w_opnd_nxt;
            r_neg1   <= w_neg1_nxt;
            r_neg2   <= w_neg2_nxt;
            r_is_div <= w_is_div_nxt;
            r_div0   <= w_div0_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign stall = r_busy & (rd_hilo | start | hi_we | lo_we);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: driver pushes model results, monitor pops on done.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, flush, hi_we, lo_we, rd_hilo;
    logic [1:0]  op;
    logic [31:0] in1, in2, wdata;
    logic        busy, done, stall;
    logic [31:0] hi, lo;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .in1(in1), .in2(in2),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .rd_hilo(rd_hilo),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    int          checks = 0;
    int          failures = 0;
    int          n_done = 0;
    res_t        sb_q[$];
    res_t        mon_exp;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Architectural result computed with plain 64-bit arithmetic
    function automatic res_t ref_model(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p, q, r;
        longint unsigned up;
        res_t            res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        case (f_op)
            2'b00: begin p = sa * sb; res.hi = p[63:32]; res.lo = p[31:0]; end
            2'b01: begin up = {32'd0, a} * {32'd0, b}; res.hi = up[63:32]; res.lo = up[31:0]; end
            2'b10: begin
                if (b == 32'd0) begin res.lo = 32'hFFFF_FFFF; res.hi = a; end
                else begin q = sa / sb; r = sa % sb; res.lo = q[31:0]; res.hi = r[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin res.lo = 32'hFFFF_FFFF; res.hi = a; end
                else begin res.lo = a / b; res.hi = a % b; end
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expected result
    always @(negedge clk) begin
        if (reset_n && done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual hi=%h lo=%h required=no done pulse", hi, lo);
            end else begin
                mon_exp = sb_q.pop_front();
                check("result_hi", 64'(hi), 64'(mon_exp.hi));
                check("result_lo", 64'(lo), 64'(mon_exp.lo));
                m_hi = mon_exp.hi;
                m_lo = mon_exp.lo;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
        op    = f_op;
        in1   = a;
        in2   = b;
        start = 1'b1;
        sb_q.push_back(ref_model(f_op, a, b));
        step();
        start = 1'b0;
        op    = 2'($urandom);
        in1   = $urandom;
        in2   = $urandom;
    endtask

    // Called right after issue(); returns at the negedge of the done cycle
    task automatic wait_done(input logic rd);
        int   k, nbusy, bad;
        logic got;
        k = 0; nbusy = 0; bad = 0; got = 1'b0;
        rd_hilo = rd;
        while (!got && k < 60) begin
            @(negedge clk);
            k++;
            if (done) got = 1'b1;
            else begin
                if (busy) nbusy++;
                if (!busy || stall !== rd) bad++;
            end
        end
        check("done_latency", 64'(k), 64'd34);
        check("busy_cycles", 64'(nbusy), 64'd33);
        check("busy_stall", 64'(bad), 64'd0);
        if (rd) check("stall_in_done", 64'(stall), 64'd0);
        rd_hilo = 1'b0;
    endtask

    task automatic wait_any();
        int   k;
        logic got;
        k = 0; got = 1'b0;
        while (!got && k < 60) begin
            @(negedge clk);
            k++;
            if (done) got = 1'b1;
        end
        check("done_seen", 64'(got), 64'd1);
    endtask

    task automatic mt(input logic is_hi, input logic [31:0] d);
        wdata = d;
        hi_we = is_hi;
        lo_we = !is_hi;
        step();
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (is_hi) m_hi = d; else m_lo = d;
        @(negedge clk);
        check(is_hi ? "mthi" : "mtlo", 64'(is_hi ? hi : lo), 64'(is_hi ? m_hi : m_lo));
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bad, d0;
        logic rd;
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        rd_hilo = 1'b0; op = 2'b00; in1 = '0; in2 = '0; wdata = '0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        step();
        reset_n = 1'b1;
        step();

        mt(1'b1, 32'h1234_5678);
        mt(1'b0, 32'h9ABC_DEF0);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(1'b1); step();
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);         wait_done(1'b0); step();
        issue(2'b11, 32'd100, 32'd7);               wait_done(1'b0); step();
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);         wait_done(1'b1); step();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(1'b0); step();
        issue(2'b10, 32'd5, 32'd0);                 wait_done(1'b0); step();
        issue(2'b10, 32'hFFFF_FFF0, 32'd0);         wait_done(1'b0); step();
        issue(2'b11, 32'hDEAD_BEEF, 32'd0);         wait_done(1'b0); step();

        // MTHI/MTLO while busy are dropped and stalled
        issue(2'($urandom), pick(), pick());
        repeat (3) step();
        wdata = 32'hDEAD_BEEF; hi_we = 1'b1; lo_we = 1'b1;
        #1;
        check("stall_on_mt", 64'(stall), 64'd1);
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        @(negedge clk);
        check("mt_busy_hi", 64'(hi), 64'(m_hi));
        check("mt_busy_lo", 64'(lo), 64'(m_lo));
        wait_any(); step();

        // Second start while busy is ignored
        issue(2'b00, 32'hFFFF_FF00, 32'h0000_1234);
        repeat (4) step();
        d0 = n_done;
        start = 1'b1; op = 2'b01; in1 = $urandom; in2 = $urandom;
        #1;
        check("stall_on_start", 64'(stall), 64'd1);
        step();
        start = 1'b0;
        wait_any();
        repeat (40) step();
        check("single_done", 64'(n_done - d0), 64'd1);

        // Flush in the 10th CALC cycle
        issue(2'b01, 32'h0BAD_F00D, 32'h1357_9BDF);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (hi !== m_hi || lo !== m_lo || busy) bad++;
        end
        check("flush_hold", 64'(bad), 64'd0);
        step();

        // Flush beats start in IDLE
        flush = 1'b1; start = 1'b1; op = 2'b00; in1 = 32'd3; in2 = 32'd3;
        step();
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check("flush_start_busy", 64'(busy), 64'd0);
        step();

        // Back-to-back: start in the done cycle
        issue(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFD); wait_done(1'b0);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000); wait_done(1'b1);
        step();

        for (int i = 0; i < 24; i++) begin
            rd = 1'($urandom);
            if ($urandom_range(0, 3) == 0) mt(1'($urandom), $urandom);
            issue(2'($urandom), pick(), pick());
            wait_done(rd);
            step();
        end

        // Asynchronous reset mid-CALC
        mt(1'b1, 32'hCAFE_F00D);
        issue(2'b01, 32'd1234, 32'd5678);
        repeat (12) step();
        #2;
        reset_n = 1'b0;
        #1;
        check("amid_rst_busy", 64'(busy), 64'd0);
        check("amid_rst_done", 64'(done), 64'd0);
        check("amid_rst_hi", 64'(hi), 64'd0);
        check("amid_rst_lo", 64'(lo), 64'd0);
        sb_q.delete();
        m_hi = '0; m_lo = '0;
        step(); step();
        reset_n = 1'b1;
        step();
        issue(2'b11, 32'hFFFF_FFFF, 32'd16); wait_done(1'b1); step();

        repeat (3) step();
        check("queue_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide unit for the pipelined CPU. It takes MULT/MULTU/DIV/DIVU operations issued from the EX stage and runs them over 33 cycles next to the single-cycle ALU. Results go into architectural HI/LO registers owned by this block. The block also generates the pipeline stall for any instruction that reads HI/LO while an operation is in flight.

## Interface
- `WIDTH`, default 32, operand width; HI and LO are each `WIDTH` bits.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: issue request, sampled only in IDLE.
- `op` in 2: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `in1` in WIDTH: multiplicand / dividend (rs).
- `in2` in WIDTH: multiplier / divisor (rt).
- `flush` in 1: abort the operation in flight (branch/exception squash).
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in WIDTH: MTHI/MTLO data.
- `rd_hilo` in 1: the instruction in ID/EX reads HI or LO (MFHI/MFLO).
- `busy` out 1: operation in flight (registered).
- `done` out 1: one-cycle pulse; HI/LO were updated at the preceding edge.
- `hi` out WIDTH: HI register (registered).
- `lo` out WIDTH: LO register (registered).
- `stall` out 1: combinational, equals `busy & (rd_hilo | start | hi_we | lo_we)`.

## Operation
- **States:** IDLE, CALC, FIX. An internal 5-bit iteration counter `cnt` runs during CALC.
- **IDLE + `start`:**
  - Capture |in1| and |in2| as magnitudes. MULTU/DIVU always treat operands as unsigned; MULT/DIV take the two's-complement magnitude, so 0x80000000 gives magnitude 2^31.
  - Capture both sign bits and `op`. Go to CALC with `cnt`=0.
- **CALC, multiply:**
  - Radix-2 shift-add on a 64-bit accumulator, one bit per cycle, 32 cycles.
  - After `cnt`=31 go to FIX.
- **CALC, divide:**
  - Restoring division, one quotient bit per cycle, 32 cycles, using a 33-bit partial remainder.
  - After `cnt`=31 go to FIX.
- **FIX:**
  - Apply sign correction and write HI/LO, then return to IDLE with `done`=1.
  - MULT: negate the 64-bit product if the signs differ. HI = product[63:32], LO = product[31:0].
  - DIV: negate the quotient if the signs differ; negate the remainder if the dividend was negative. LO = quotient, HI = remainder.
  - Divide by zero, signed or unsigned: LO = 0xFFFFFFFF and HI = `in1` as captured, raw bits and not the magnitude. No trap is raised.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of the magnitude algorithm; no special case is needed.
- **MTHI/MTLO:**
  - `hi_we`/`lo_we` write `wdata` at the next edge only in IDLE. They are ignored while busy, and `stall` holds the writer.
  - Write and `start` in the same IDLE cycle: the write is applied and the operation proceeds. The final result overwrites HI/LO.
- **flush:**
  - In CALC or FIX: return to IDLE at the next edge. HI/LO are unchanged and `done` does not pulse.
  - In IDLE: `flush` takes priority over a simultaneous `start`; nothing is issued.
- **start while busy:** ignored and not queued. `stall` holds the issuing instruction.

## Timing
- **Reset:** asserting `reset_n` low, including mid-operation, immediately forces state IDLE, `cnt`=0, `busy`=0, `done`=0, `hi`=0, `lo`=0.
- **Latency:**
  - `start` is sampled at edge E.
  - `busy`=1 from after E through the cycle ending at edge E+33, i.e. 33 cycles.
  - HI/LO update at E+33; `done`=1 for the single cycle following E+33.
- **Back-to-back:** a `start` in the cycle where `done`=1 is accepted, since state is already IDLE. Sustained throughput is one operation per 34 cycles.
- **stall:**
  - Purely combinational from registered `busy` and same-cycle inputs; there is no path from `stall` back into state.
  - It drops in the `done` cycle, so MFHI/MFLO then reads the new value directly from the `hi`/`lo` registers.
- No state or output ever depends on `in1`/`in2` outside the `start` capture edge.

## Test plan
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF -> `done` exactly 33 cycles after the start edge; HI=0xFFFFFFFE, LO=0x00000001; `busy` high for 33 cycles.
- **MULT and DIVU:**
  - MULT −3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - DIVU 100 / 7 -> LO=14, HI=2.
- **DIV corner cases:**
  - DIV −7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - DIV 5 / 0 -> LO=0xFFFFFFFF, HI=5.
- **Abort:**
  - `flush` in the 10th CALC cycle -> `busy`=0 next cycle, HI/LO keep their prior values, no `done`.
  - `reset_n` low mid-CALC -> HI/LO/`busy`/`done` immediately 0.
- **Stall and ignored requests:**
  - `rd_hilo`=1 throughout an operation -> `stall`=1 every busy cycle and 0 in the `done` cycle.
  - A second `start` issued while busy is ignored: exactly one `done`, with the first operation's result.
- **MTHI/MTLO and back-to-back:**
  - `hi_we` with 0x12345678 in IDLE -> HI=0x12345678.
  - `hi_we` while busy -> HI unchanged.
  - `start` in the `done` cycle -> a second `done` 33 cycles later with the correct result.
